// File: rtl/shift_reg_piso_tx.sv
// MSB-first parallel-in serial-out transmitter with a valid/ready word input; first bit one clock after accept.
// Define PARITY_EN to append an even-parity bit after each word (adds the PAR state).
module shift_reg_piso_tx #(
   parameter  int WIDTH = 4,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sdo,
   output logic             sdo_valid,
   output logic             busy,
   output logic             done
);

`ifdef PARITY_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_sdo, w_sdo_nxt;
   logic             r_sdo_valid, w_sdo_valid_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic             w_ready;
   logic             w_accept;
`ifdef PARITY_EN
   logic             r_par, w_par_nxt;
`endif

   // Ready only where the next edge may legally start a new word.
   always_comb begin
      w_ready = 1'b0;
      case (r_state)
         S_IDLE:  w_ready = 1'b1;
`ifdef PARITY_EN
         S_PAR:   w_ready = 1'b1;
`else
         S_SHIFT: w_ready = (r_cnt == '0);
`endif
         default: w_ready = 1'b0;
      endcase
      if (reset) begin
         w_ready = 1'b0;
      end
   end

   assign din_ready = w_ready;
   assign w_accept  = din_valid && w_ready;

   always_comb begin
      w_state_nxt     = r_state;
      w_shreg_nxt     = r_shreg;
      w_cnt_nxt       = r_cnt;
      w_sdo_nxt       = r_sdo;
      w_sdo_valid_nxt = r_sdo_valid;
      w_busy_nxt      = r_busy;
      w_done_nxt      = 1'b0;
`ifdef PARITY_EN
      w_par_nxt       = r_par;
`endif
      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_IDLE;
         end
         S_SHIFT: begin
            if (r_cnt != '0) begin
               w_sdo_nxt   = r_shreg[WIDTH-1];
               w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
               w_cnt_nxt   = r_cnt - 1'b1;
            end else begin
`ifdef PARITY_EN
               w_state_nxt = S_PAR;
               w_sdo_nxt   = r_par;
`else
               w_done_nxt      = 1'b1;
               w_state_nxt     = S_IDLE;
               w_sdo_nxt       = 1'b0;
               w_sdo_valid_nxt = 1'b0;
               w_busy_nxt      = 1'b0;
`endif
            end
         end
`ifdef PARITY_EN
         S_PAR: begin
            w_done_nxt      = 1'b1;
            w_state_nxt     = S_IDLE;
            w_sdo_nxt       = 1'b0;
            w_sdo_valid_nxt = 1'b0;
            w_busy_nxt      = 1'b0;
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      // A load overrides the wind-down so consecutive words run gap-free.
      if (w_accept) begin
         w_state_nxt     = S_SHIFT;
         w_sdo_nxt       = din[WIDTH-1];
         w_sdo_valid_nxt = 1'b1;
         w_shreg_nxt     = {din[WIDTH-2:0], 1'b0};
         w_cnt_nxt       = CNT_W'(WIDTH-1);
         w_busy_nxt      = 1'b1;
`ifdef PARITY_EN
         w_par_nxt       = ^din;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_shreg     <= '0;
         r_cnt       <= '0;
         r_sdo       <= 1'b0;
         r_sdo_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
`ifdef PARITY_EN
         r_par       <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_shreg     <= w_shreg_nxt;
         r_cnt       <= w_cnt_nxt;
         r_sdo       <= w_sdo_nxt;
         r_sdo_valid <= w_sdo_valid_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
`ifdef PARITY_EN
         r_par       <= w_par_nxt;
`endif
      end
   end

   assign sdo       = r_sdo;
   assign sdo_valid = r_sdo_valid;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Directed bench for shift_reg_piso_tx with a 4-bit SIPO receiver model on sdo.
// Per-cycle logs are shifted in oldest-first, so expected constants read left-to-right in time order.
module tb_shift_reg_piso_tx;

   logic       clk;
   logic       reset;
   logic [3:0] din;
   logic       din_valid;
   logic       din_ready;
   logic       sdo;
   logic       sdo_valid;
   logic       busy;
   logic       done;
   logic [3:0] sipo_q;

   int n_tests;
   int n_fail;

   logic [15:0] s_log, v_log, b_log, d_log, r_log;

   shift_reg_piso_tx #(.WIDTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .sdo       (sdo),
      .sdo_valid (sdo_valid),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)          sipo_q <= 4'b0000;
      else if (sdo_valid) sipo_q <= {sipo_q[2:0], sdo};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      s_log = '0; v_log = '0; b_log = '0; d_log = '0; r_log = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      s_log = {s_log[14:0], sdo};
      v_log = {v_log[14:0], sdo_valid};
      b_log = {b_log[14:0], busy};
      d_log = {d_log[14:0], done};
      r_log = {r_log[14:0], din_ready};
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      reset     = 1'b1;
      din       = 4'h0;
      din_valid = 1'b0;
      clear_logs();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_outs", {sdo, sdo_valid, busy, done}, 4'b0000);
      check("rst_ready", din_ready, 1'b0);
      reset = 1'b0;
      #1;
      check("post_rst_ready", din_ready, 1'b1);

      // Idle hold for 10 cycles
      for (int i = 0; i < 10; i++) begin
         step();
         check("idle_hold", {sdo, sdo_valid, busy, din_ready, done}, 5'b00010);
      end

`ifdef PARITY_EN
      // 1011 (parity 1) then 1001 (parity 0), held valid back-to-back
      clear_logs();
      din = 4'b1011; din_valid = 1'b1;
      step();
      din = 4'b1001;
      step(); step(); step(); step();
      check("par_ready_in_par", din_ready, 1'b1);
      step();
      din_valid = 1'b0; din = 4'h0;
      step(); step(); step(); step(); step();
      check("par_sdo",  s_log, 16'b00000_10111100100);
      check("par_vld",  v_log, 16'b00000_11111111110);
      check("par_busy", b_log, 16'b00000_11111111110);
      check("par_done", d_log, 16'b00000_00000100001);
      check("par_ready", r_log, 16'b00000_00001000011);
`else
      // Single word 1011
      clear_logs();
      din = 4'b1011; din_valid = 1'b1;
      step();
      din_valid = 1'b0; din = 4'h0;
      repeat (5) step();
      check("single_sdo",  s_log, 16'b101100);
      check("single_vld",  v_log, 16'b111100);
      check("single_busy", b_log, 16'b111100);
      check("single_done", d_log, 16'b000010);
      check("single_sipo", sipo_q, 4'b1011);

      // Back-to-back A then 5 held valid
      clear_logs();
      din = 4'hA; din_valid = 1'b1;
      step();
      din = 4'h5;
      repeat (4) step();
      din_valid = 1'b0; din = 4'h0;
      repeat (5) step();
      check("b2b_sdo",  s_log, 16'b1010010100);
      check("b2b_vld",  v_log, 16'b1111111100);
      check("b2b_busy", b_log, 16'b1111111100);
      check("b2b_done", d_log, 16'b0000100010);
      check("b2b_sipo", sipo_q, 4'h5);

      // 4'hF offered while 1001 is mid-word: held off until cnt==0
      clear_logs();
      din = 4'b1001; din_valid = 1'b1;
      step();
      din = 4'hF;
      repeat (4) step();
      din_valid = 1'b0; din = 4'h0;
      repeat (5) step();
      check("ign_sdo",   s_log, 16'b1001111100);
      check("ign_ready", r_log, 16'b0001000111);
      check("ign_done",  d_log, 16'b0000100010);
`endif

      // Reset asserted between edges after two bits of 1100
      din = 4'b1100; din_valid = 1'b1;
      step();
      din_valid = 1'b0; din = 4'h0;
      step();
      check("mid_pre_rst", {sdo, sdo_valid, busy}, 3'b111);
      #3;
      reset = 1'b1;
      #1;
      check("mid_rst_outs", {sdo, sdo_valid, busy, done}, 4'b0000);
      check("mid_rst_ready", din_ready, 1'b0);
      @(posedge clk);
      #1;
      check("mid_rst_hold", {sdo, sdo_valid, busy, done, din_ready}, 5'b00000);
      reset = 1'b0;
      #1;
      check("mid_rel_ready", din_ready, 1'b1);

      clear_logs();
      din = 4'b0110; din_valid = 1'b1;
      step();
      din_valid = 1'b0; din = 4'h0;
      repeat (6) step();
`ifdef PARITY_EN
      check("after_rst_sdo",  s_log, 16'b0110000);
      check("after_rst_vld",  v_log, 16'b1111100);
      check("after_rst_done", d_log, 16'b0000010);
`else
      check("after_rst_sdo",  s_log, 16'b0110000);
      check("after_rst_vld",  v_log, 16'b1111000);
      check("after_rst_done", d_log, 16'b0000100);
`endif
      check("after_rst_sipo", sipo_q, 4'b0110);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
